// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the word/strobe widths, the FSM state encoding, the latency-counter
// width and the byte-lane merge used by the storage array.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int STRB_W = WORD_W / 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Replace the byte lanes of old_word selected by strb with the lanes of new_word.
    function automatic logic [WORD_W-1:0] strb_merge(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [STRB_W-1:0] strb
    );
        logic [WORD_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between the load/store unit (master) and the
// data-memory responder (slave).
interface dmem_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_bytearray.sv
// DEPTH x 32-bit word storage with per-byte-lane synchronous write and a
// combinational read of the same index. Contents are never reset.
module dmem_bytearray
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = 6
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [STRB_W-1:0] i_wstrb,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    // Commit the enabled byte lanes of the addressed word.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_idx] <= strb_merge(r_mem[i_idx], i_wdata, i_wstrb);
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, fixed access latency,
// byte-strobe writes and a registered response held until accepted.
// Optional feature macro: DMEM_ERR_EN (misaligned / out-of-range requests
// return an error response and never write memory).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic  i_clk,
    input  logic  i_reset,
    dmem_if.slave bus
);

    localparam int               IDX_W      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(LATENCY - 1);
    localparam logic [31:0]      ADDR_LIMIT = 32'(DEPTH * 4);

    dmem_state_t       r_state;
    dmem_state_t       w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    // Request captured at acceptance, used when the access happens later.
    logic              r_we;
    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_req_err;

    // Response registers, stable for the whole RESP state.
    logic [WORD_W-1:0] r_rdata;
    logic              r_err;

    logic              w_req_fire;
    logic [IDX_W-1:0]  w_req_idx;
    logic              w_req_err;
    logic              w_acc_fire;
    logic              w_acc_we;
    logic [IDX_W-1:0]  w_acc_idx;
    logic [WORD_W-1:0] w_acc_wdata;
    logic [STRB_W-1:0] w_acc_wstrb;
    logic              w_acc_err;
    logic              w_mem_we;
    logic [WORD_W-1:0] w_mem_rdata;

    assign w_req_idx = bus.req_addr[IDX_W+1:2];

`ifdef DMEM_ERR_EN
    assign w_req_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr >= ADDR_LIMIT);
`else
    assign w_req_err = 1'b0;
`endif

    // Ready only when idle, and never while reset is asserted.
    assign bus.req_ready = (r_state == IDLE) && !i_reset;
    assign w_req_fire    = bus.req_valid && bus.req_ready;

    // Choose where the access comes from: the live request when LATENCY is 1,
    // otherwise the captured request when the countdown expires.
    always_comb begin
        w_acc_fire  = 1'b0;
        w_acc_we    = 1'b0;
        w_acc_idx   = '0;
        w_acc_wdata = '0;
        w_acc_wstrb = '0;
        w_acc_err   = 1'b0;
        if (LATENCY == 1) begin
            w_acc_fire  = w_req_fire;
            w_acc_we    = bus.req_we;
            w_acc_idx   = w_req_idx;
            w_acc_wdata = bus.req_wdata;
            w_acc_wstrb = bus.req_wstrb;
            w_acc_err   = w_req_err;
        end else begin
            w_acc_fire  = (r_state == BUSY) && (r_cnt == {CNT_W{1'b0}});
            w_acc_we    = r_we;
            w_acc_idx   = r_idx;
            w_acc_wdata = r_wdata;
            w_acc_wstrb = r_wstrb;
            w_acc_err   = r_req_err;
        end
    end

    assign w_mem_we = w_acc_fire && w_acc_we && !w_acc_err;

    dmem_bytearray #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (w_mem_we),
        .i_idx   (w_acc_idx),
        .i_wdata (w_acc_wdata),
        .i_wstrb (w_acc_wstrb),
        .o_rdata (w_mem_rdata)
    );

    // Next-state and latency-counter decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_req_fire) begin
                    w_cnt_nxt = CNT_LOAD;
                    if (LATENCY == 1) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = BUSY;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (r_cnt == {CNT_W{1'b0}}) begin
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt   = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                    w_state_nxt = BUSY;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RESP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, captured request and response registers; reset drops any
    // in-flight transaction.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_cnt     <= {CNT_W{1'b0}};
            r_we      <= 1'b0;
            r_idx     <= {IDX_W{1'b0}};
            r_wdata   <= {WORD_W{1'b0}};
            r_wstrb   <= {STRB_W{1'b0}};
            r_req_err <= 1'b0;
            r_rdata   <= {WORD_W{1'b0}};
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_req_fire) begin
                r_we      <= bus.req_we;
                r_idx     <= w_req_idx;
                r_wdata   <= bus.req_wdata;
                r_wstrb   <= bus.req_wstrb;
                r_req_err <= w_req_err;
            end
            if (w_acc_fire) begin
                r_err <= w_acc_err;
                if (w_acc_we || w_acc_err) begin
                    r_rdata <= {WORD_W{1'b0}};
                end else begin
                    r_rdata <= w_mem_rdata;
                end
            end
        end
    end

    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

endmodule
